// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tt_sweep_ctrl
//  Purpose  : Truth-table sweep sequencer. On start it steps fu_in through
//             0..2^W-1, holds each vector for SETTLE cycles, then samples the
//             1-bit fu_out into table_q[fu_in].
//  Options  : TT_SWEEP_COUNT_EN adds ones_cnt, the number of 1s captured in
//             the current sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tt_sweep_ctrl #(
    parameter int W      = 5,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [W-1:0]        fu_in,
    input  logic                fu_out,
    output logic                busy,
    output logic                done,
    output logic                table_valid,
    output logic [(2**W)-1:0]   table_q
`ifdef TT_SWEEP_COUNT_EN
    ,
    output logic [W:0]          ones_cnt
`endif
);

    // Last vector index and the settle-counter value that ends a DRIVE phase.
    localparam logic [W-1:0] c_last_idx   = W'((2**W) - 1);
    localparam logic [3:0]   c_settle_end = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [W-1:0]        r_idx;
    logic [3:0]          r_wait;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic [(2**W)-1:0]   r_table;
`ifdef TT_SWEEP_COUNT_EN
    logic [W:0]          r_ones;
`endif

    // Sweep state machine; rst outranks abort, abort outranks every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_table <= '0;
`ifdef TT_SWEEP_COUNT_EN
            r_ones  <= '0;
`endif
        end else if (abort) begin
            // Partial table contents are deliberately kept for inspection.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
`ifdef TT_SWEEP_COUNT_EN
            r_ones  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_DRIVE;
                        r_idx   <= '0;
                        r_wait  <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_table <= '0;
`ifdef TT_SWEEP_COUNT_EN
                        r_ones  <= '0;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (r_wait == c_settle_end) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_table[r_idx] <= fu_out;
`ifdef TT_SWEEP_COUNT_EN
                    r_ones <= r_ones + (W+1)'(fu_out);
`endif
                    // Terminal check comes first so idx never wraps.
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_DRIVE;
                        r_idx   <= r_idx + 1'b1;
                        r_wait  <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign fu_in       = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign table_valid = r_valid;
    assign table_q     = r_table;
`ifdef TT_SWEEP_COUNT_EN
    assign ones_cnt    = r_ones;
`endif

endmodule
`default_nettype wire

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer for the lab's combinational logic-function units: the 5-input encoder/decoder networks and similar blocks. On a start request it drives every input vector 0..2^W-1 into the function unit, waits a settle interval, and samples the 1-bit result into a truth-table register. It sits between the board-level control (buttons/switches) and the function unit, so one sweep characterises the whole function for display or comparison against a golden table.

## Interface
Parameters:
- W, 5: function-unit input width; table holds 2^W bits.
- SETTLE, 1: hold cycles per vector before sampling; legal range 1..15.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; launches a sweep.
- abort  input  1  level; any state → IDLE next cycle.
- fu_in  output  W  vector driven to the function unit; registered.
- fu_out  input  1  function-unit result; combinational from fu_in.
- busy  output  1  high from first DRIVE cycle through DONE cycle.
- done  output  1  one-cycle pulse in DONE state.
- table_valid  output  1  table holds a complete sweep.
- table_q  output  2^W  bit i = fu_out sampled with fu_in = i.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: start=1 → DRIVE; idx←0, fu_in←0, wait←0, table_valid←0, table_q←0.
- DRIVE: wait increments each cycle; at wait = SETTLE-1 → SAMPLE.
- SAMPLE: table_q[idx]←fu_out. If idx = 2^W-1 → DONE; else idx←idx+1, fu_in←idx+1, wait←0 → DRIVE.
- DONE: done=1, table_valid←1 → IDLE.
- fu_in always equals idx; idx is W bits and never wraps (terminal check precedes increment).
- start is ignored outside IDLE; held high, a new sweep begins the cycle after DONE.
- abort has priority over every transition, start included. Next cycle: IDLE, busy=0, done=0, table_valid=0. table_q keeps its partial contents. No done pulse.
- rst has priority over abort. All outputs 0: fu_in=0, busy=0, done=0, table_valid=0, table_q=0, state IDLE.

## Timing
- start sampled at edge 0 → first DRIVE cycle 1, fu_in=0.
- Per vector: SETTLE DRIVE cycles + 1 SAMPLE cycle.
- done high in cycle 1 + 2^W·(SETTLE+1).
  - Default W=5, SETTLE=1: cycle 65.
- table_valid rises in the cycle after done and stays high until the next start, abort or rst.
- busy deasserts in the cycle after done.
- Earliest restart: start sampled in the IDLE cycle after DONE.
- fu_out is sampled at the end of the SAMPLE cycle. The function unit gets SETTLE+1 cycles of stable fu_in.

## Configuration
- TT_SWEEP_COUNT_EN defined:
  - Adds output ones_cnt (width W+1): count of 1s captured in the current sweep.
  - Cleared at start, abort and rst; incremented in SAMPLE when fu_out=1.
  - Final value valid when table_valid=1.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset mid-sweep: rst at cycle 20 of a sweep → next cycle all outputs 0, state IDLE, start ignored until rst falls.
- AND model: bench model fu_out=&fu_in, W=5, SETTLE=1, start pulse at cycle 0 → done at cycle 65, table_q=32'h8000_0000, ones_cnt=1.
- Bit-0 model: fu_out=fu_in[0] → table_q=32'hAAAA_AAAA, ones_cnt=16.
  - Check fu_in stays at each value exactly 2 cycles.
  - Check busy=1 for cycles 1..65.
- Abort: abort at cycle 30 → cycle 31 busy=0, table_valid=0, no done pulse.
  - Then start → fresh sweep, table cleared, correct final table.
- start held high across 2 sweeps with SETTLE=3 → done at cycles 129 and 259; start pulses while busy have no effect.
- Simultaneous start and abort in IDLE → remains IDLE, busy stays 0.
